// File: rtl/dna_pkg.sv
// Shared definitions for the device-DNA reader and its stream transmitter.
// Widths, FSM state type, default frame header and the byte selector.
package dna_pkg;

    localparam int DNA_WIDTH = 96;
    localparam int DNA_BYTES = 12;

    localparam logic [7:0] DNA_HDR_DEFAULT = 8'hD5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DNA,
        ST_HDR,
        ST_DATA,
        ST_CSUM
    } dna_tx_state_t;

    // Byte k of the DNA word, counted from the top or the bottom.
    function automatic logic [7:0] dna_byte(
        input logic [DNA_WIDTH-1:0] v,
        input logic [3:0]           k,
        input bit                   msb_first
    );
        logic [7:0] res;
        res = 8'h00;
        for (int i = 0; i < DNA_BYTES; i++) begin
            if (k == 4'(i)) begin
                if (msb_first)
                    res = v[DNA_WIDTH-1-8*i -: 8];
                else
                    res = v[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dna_stream_tx.sv
// Sends the latched device DNA as a framed AXI4-Stream byte packet:
// optional header, 12 DNA bytes, XOR checksum carrying tlast.
module dna_stream_tx
    import dna_pkg::*;
#(
    parameter bit         HEADER_EN   = 1'b1,
    parameter logic [7:0] HEADER_BYTE = DNA_HDR_DEFAULT,
    parameter bit         MSB_FIRST   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DNA_WIDTH-1:0] dna_i,
    input  logic                 dna_valid_i,
    input  logic                 send_i,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output logic [15:0]          frame_count_o
);

    localparam dna_tx_state_t FIRST_ST =
        HEADER_EN ? ST_HDR : ST_DATA;
    localparam logic [3:0] LAST_IDX = 4'(DNA_BYTES - 1);

    dna_tx_state_t        state_q;
    dna_tx_state_t        state_d;
    logic [3:0]           idx_q;
    logic [DNA_WIDTH-1:0] shadow_q;
    logic [7:0]           csum_q;
    logic                 pending_q;
    logic                 done_q;
    logic [15:0]          frame_cnt_q;

    logic       req;
    logic       hs;
    logic       leaving;
    logic [7:0] cur_byte;

    assign req      = send_i | pending_q;
    assign hs       = m_axis_tvalid & m_axis_tready;
    assign cur_byte = dna_byte(shadow_q, idx_q, MSB_FIRST);

    // A frame starts on the cycle the FSM moves out of IDLE/WAIT_DNA.
    assign leaving =
        (state_q == ST_IDLE || state_q == ST_WAIT_DNA) &&
        (state_d == ST_HDR  || state_d == ST_DATA);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; byte states only advance on a handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req)
                    state_d = dna_valid_i ? FIRST_ST : ST_WAIT_DNA;
            end
            ST_WAIT_DNA: begin
                if (dna_valid_i)
                    state_d = FIRST_ST;
            end
            ST_HDR: begin
                if (hs)
                    state_d = ST_DATA;
            end
            ST_DATA: begin
                if (hs && idx_q == LAST_IDX)
                    state_d = ST_CSUM;
            end
            ST_CSUM: begin
                if (hs)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stream outputs decode from registered state only, so they hold
    // steady for as long as the sink stalls.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = 8'h00;
        busy_o        = (state_q != ST_IDLE);
        unique case (state_q)
            ST_HDR: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = HEADER_BYTE;
            end
            ST_DATA: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = cur_byte;
            end
            ST_CSUM: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tdata  = csum_q;
            end
            default: ;
        endcase
    end

    // Shadow copy of the DNA and the byte index for the frame in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q <= '0;
            idx_q    <= 4'd0;
        end else if (leaving) begin
            shadow_q <= dna_i;
            idx_q    <= 4'd0;
        end else if (hs && state_q == ST_DATA) begin
            idx_q <= idx_q + 4'd1;
        end
    end

    // Running XOR over the payload bytes only.
    always_ff @(posedge clk) begin
        if (!rst_n)
            csum_q <= 8'h00;
        else if (leaving)
            csum_q <= 8'h00;
        else if (hs && state_q == ST_DATA)
            csum_q <= csum_q ^ cur_byte;
    end

    // Requests arriving while busy collapse into one queued frame.
    always_ff @(posedge clk) begin
        if (!rst_n)
            pending_q <= 1'b0;
        else if (state_q == ST_IDLE)
            pending_q <= 1'b0;
        else if (send_i)
            pending_q <= 1'b1;
    end

    // Completion pulse and wrapping frame counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_q      <= 1'b0;
            frame_cnt_q <= 16'h0000;
        end else begin
            done_q <= hs && (state_q == ST_CSUM);
            if (hs && state_q == ST_CSUM)
                frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_done_o  = done_q;
    assign frame_count_o = frame_cnt_q;

endmodule

// File: doc/dna_stream_tx.md
Name: dna_stream_tx

Overview:
- Downstream consumer of the device-DNA reader (dnaport_wrap).
- Latches the 96-bit DNA value once the reader reports it valid. On request, it emits the value as a framed byte stream on an AXI4-Stream master: optional header byte, 12 DNA bytes, then an XOR checksum byte.
- Feeds the board-ID / housekeeping packet path, so the host can identify the FPGA.

Parameters:
- HEADER_EN, 1, 1 = prepend HEADER_BYTE to every frame; 0 = no header.
- HEADER_BYTE, 8'hD5, value of the header byte.
- MSB_FIRST, 1, 1 = DNA bits [95:88] sent first; 0 = bits [7:0] sent first.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- dna_i  in  96  DNA value from the reader.
- dna_valid_i  in  1  level; high once dna_i is stable and final.
- send_i  in  1  single-cycle request to transmit one frame.
- m_axis_tdata  out  8  stream byte.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  high on the final (checksum) byte.
- busy_o  out  1  high from request acceptance until the last byte handshakes.
- frame_done_o  out  1  one-cycle pulse, the cycle after the checksum byte handshakes.
- frame_count_o  out  16  completed frames, wraps 16'hFFFF -> 0.

Behaviour:
- Reset (rst_n low at a clk edge):
  - Next cycle: state IDLE; tvalid, tlast, busy_o, frame_done_o = 0; tdata = 0; frame_count_o = 0; pending flag cleared.
  - Reset mid-frame abandons the frame; no tlast is emitted.
- States: IDLE, WAIT_DNA, HDR, DATA, CSUM.
- IDLE:
  - On send_i (or pending set): busy_o = 1 and pending is cleared.
  - If dna_valid_i = 1: go to HDR (or DATA if HEADER_EN = 0). Otherwise go to WAIT_DNA.
- WAIT_DNA: stays until dna_valid_i = 1, then proceeds as from IDLE.
- Shadow capture:
  - dna_i is copied into a 96-bit shadow register on the cycle the FSM leaves IDLE/WAIT_DNA.
  - The running XOR resets to 8'h00 on that same cycle.
  - Changes on dna_i during a frame do not affect the frame in flight.
- tvalid timing: asserted the cycle after entering HDR/DATA/CSUM.
- Handshake rules:
  - AXI-Stream: a byte transfers when tvalid and tready are both high.
  - tdata, tlast and tvalid are held stable while tready = 0.
  - No bubbles are required between bytes. With tready held at 1, the frame is contiguous: 14 cycles with header, 13 without.
- HDR: tdata = HEADER_BYTE. After the handshake, go to DATA with byte index 0.
- DATA:
  - 4-bit index runs 0..11.
  - MSB_FIRST = 1: byte k = shadow[95-8k -: 8]. MSB_FIRST = 0: byte k = shadow[8k +: 8].
  - Each handshaked byte is XORed into the checksum.
  - Index 11 handshake -> CSUM.
- CSUM:
  - tdata = XOR of the 12 DNA bytes only; the header is excluded. tlast = 1.
  - On handshake: tvalid = 0, busy_o = 0 and frame_done_o pulses on the next cycle; frame_count_o increments; go to IDLE.
- send_i while busy_o = 1:
  - Sets the pending flag. Any number of requests collapse into one queued frame.
  - That frame starts from IDLE on the cycle after frame_done_o.
- send_i on the same cycle as the final handshake also sets pending.
- dna_valid_i dropping mid-frame is ignored, because the shadow is already captured.
- tready may toggle arbitrarily. No byte may be dropped or duplicated.

Decomposition:
- Shared package dna_pkg holds:
  - DNA_WIDTH = 96 and DNA_BYTES = 12;
  - the state enum type dna_tx_state_t;
  - the default header constant.
- The same package is used by dnaport_wrap.
- Single module, no sub-module. The FSM, shadow register, byte mux and checksum are small enough to stay flat.

Test Plan:
- DNA 96'h112233445566778899AABBCC, dna_valid_i = 1, tready = 1, one send_i:
  - Stream D5,11,22,33,44,55,66,77,88,99,AA,BB,CC,CC with tlast only on the last byte.
  - 14 contiguous beats; frame_done_o pulses once; frame_count_o = 1.
- send_i issued before dna_valid_i rises (valid asserted 50 cycles later): no tvalid while waiting and busy_o = 1; the frame then matches the first case.
- Random tready (about 50 % duty), MSB_FIRST = 0, HEADER_EN = 0:
  - Stream CC,BB,AA,99,88,77,66,55,44,33,22,11,CC.
  - tdata stable whenever tvalid = 1 and tready = 0.
- Three send_i pulses during a frame:
  - Exactly two frames total, the second starting the cycle after the first frame_done_o.
  - Changing dna_i to all-ones mid-frame alters only the second frame (payload FF×12, checksum 00).
- rst_n low for 1 cycle at byte 6 with tready = 1:
  - Next cycle tvalid = 0, busy_o = 0, frame_count_o = 0.
  - A subsequent send_i yields a complete correct frame.
- 65536 frames (frame_count_o forced near wrap allowed): the count wraps FFFF -> 0000 and frame_done_o still pulses.
